mips_muldiv: RTL and testbench

- Iterative multiply/divide unit with HI/LO registers for the pipelined MIPS core; services MULT, MULTU, DIV, DIVU, MTHI and MTLO.
- Sits beside the EX stage. The core holds the issuing instruction while busy=1, and reads hi/lo for MFHI/MFLO.
- Generalises the fixed 32-bit datapath: parametrised width, optional signed support, multi-cycle sequencing, and abort on pipeline flush.

---
 rtl/mips_muldiv_pkg.sv | 31 +++
 rtl/mips_muldiv_step.sv | 53 +++++
 rtl/mips_muldiv.sv | 173 +++++++++++++++++
 tb/tb_mips_muldiv.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/mips_muldiv_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mips_muldiv_pkg
// Purpose  : Shared definitions for the MIPS multiply/divide unit.
//            - Op encodings for the issue interface.
//            - FSM state encodings.
//            - Iteration-counter width helper.
// Revision : 1.0 - initial release
// ============================================================================
package mips_muldiv_pkg;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        CALC  = 2'd1,
        FIXUP = 2'd2
    } md_state_t;

    // The counter must be able to hold the value WIDTH itself.
    function automatic int md_cnt_width(input int width);
        return $clog2(width) + 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/mips_muldiv_step.sv
`default_nettype none
// ============================================================================
// Module   : muldiv_step
// Purpose  : Combinational single radix-2 iteration for multiply and divide.
//            Multiply: shift-add; {acc_hi,acc_lo} is the partial product with
//                      the remaining multiplier bits in acc_lo.
//            Divide  : restoring shift-subtract; acc_hi is the partial
//                      remainder, acc_lo the dividend bits / quotient bits.
// Ports    : is_div          - 1 = divide iteration, 0 = multiply iteration
//            acc_hi, acc_lo  - current accumulator halves
//            operand         - multiplicand magnitude or divisor magnitude
//            nxt_hi, nxt_lo  - accumulator halves after this iteration
// Revision : 1.0 - initial release
// ============================================================================
module muldiv_step #(
    parameter int WIDTH = 32
) (
    input  logic             is_div,
    input  logic [WIDTH-1:0] acc_hi,
    input  logic [WIDTH-1:0] acc_lo,
    input  logic [WIDTH-1:0] operand,
    output logic [WIDTH-1:0] nxt_hi,
    output logic [WIDTH-1:0] nxt_lo
);

    logic [WIDTH:0] w_sum;
    logic [WIDTH:0] w_shifted;
    logic [WIDTH:0] w_diff;

    always_comb begin
        // Extra bit keeps the carry out of the partial-product add.
        w_sum     = {1'b0, acc_hi} + (acc_lo[0] ? {1'b0, operand} : '0);
        w_shifted = {acc_hi, acc_lo[WIDTH-1]};
        w_diff    = w_shifted - {1'b0, operand};
        nxt_hi    = '0;
        nxt_lo    = '0;
        if (is_div) begin
            // Top bit of the difference set means a borrow: restore.
            if (!w_diff[WIDTH]) begin
                nxt_hi = w_diff[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b1};
            end else begin
                nxt_hi = w_shifted[WIDTH-1:0];
                nxt_lo = {acc_lo[WIDTH-2:0], 1'b0};
            end
        end else begin
            nxt_hi = w_sum[WIDTH:1];
            nxt_lo = {w_sum[0], acc_lo[WIDTH-1:1]};
        end
    end

endmodule
`default_nettype wire

// File: rtl/mips_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : mips_muldiv
// Purpose  : Iterative multiply/divide unit with HI/LO registers.
//            MULT/MULTU/DIV/DIVU take WIDTH iterations plus one fix-up cycle;
//            MTHI/MTLO write HI/LO directly from IDLE.
// Ports    : clk, reset      - clock, synchronous active-high reset
//            start, op, a, b - issue request, opcode and operands
//            flush           - abort the in-flight operation
//            busy            - operation in progress
//            done            - one-cycle pulse after hi/lo commit
//            hi, lo          - HI and LO registers
// Revision : 1.0 - initial release
// ============================================================================
module mips_muldiv
    import mips_muldiv_pkg::*;
#(
    parameter int WIDTH     = 32,
    parameter bit SIGNED_EN = 1'b1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [2:0]       op,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             flush,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    localparam int CNT_W = md_cnt_width(WIDTH);

    md_state_t          r_state;
    md_state_t          w_state_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [WIDTH-1:0]   r_acc_hi;
    logic [WIDTH-1:0]   r_acc_lo;
    logic [WIDTH-1:0]   r_operand;
    logic               r_is_div;
    logic               r_neg_lo;   // negate product / quotient
    logic               r_neg_hi;   // negate remainder (dividend sign)
    logic               r_div0;
    logic [WIDTH-1:0]   r_hi;
    logic [WIDTH-1:0]   r_lo;
    logic               r_done;

    logic               w_arith_op;
    logic               w_signed_op;
    logic               w_sa;
    logic               w_sb;
    logic [WIDTH-1:0]   w_abs_a;
    logic [WIDTH-1:0]   w_abs_b;
    logic [WIDTH-1:0]   w_step_hi;
    logic [WIDTH-1:0]   w_step_lo;
    logic [2*WIDTH-1:0] w_prod_fix;
    logic [WIDTH-1:0]   w_quot_fix;
    logic [WIDTH-1:0]   w_rem_fix;

    // ---------------------------------------------------------------- issue
    always_comb begin
        w_arith_op  = (op <= MD_DIVU);
        w_signed_op = SIGNED_EN && ((op == MD_MULT) || (op == MD_DIV));
        w_sa        = w_signed_op & a[WIDTH-1];
        w_sb        = w_signed_op & b[WIDTH-1];
        w_abs_a     = w_sa ? (~a + 1'b1) : a;
        w_abs_b     = w_sb ? (~b + 1'b1) : b;
    end

    // ------------------------------------------------------------- datapath
    muldiv_step #(
        .WIDTH (WIDTH)
    ) u_step (
        .is_div  (r_is_div),
        .acc_hi  (r_acc_hi),
        .acc_lo  (r_acc_lo),
        .operand (r_operand),
        .nxt_hi  (w_step_hi),
        .nxt_lo  (w_step_lo)
    );

    // Sign correction. A zero divisor leaves the remainder equal to |a|, so
    // re-applying the dividend sign returns a unchanged on hi; the quotient
    // is forced to all ones regardless of operand signs.
    always_comb begin
        w_prod_fix = r_neg_lo ? (~{r_acc_hi, r_acc_lo} + 1'b1) : {r_acc_hi, r_acc_lo};
        w_quot_fix = r_div0 ? '1 : (r_neg_lo ? (~r_acc_lo + 1'b1) : r_acc_lo);
        w_rem_fix  = r_neg_hi ? (~r_acc_hi + 1'b1) : r_acc_hi;
    end

    // ------------------------------------------------------------------ FSM
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start && !flush && w_arith_op) w_state_nxt = CALC;
            CALC:    if (flush)                          w_state_nxt = IDLE;
                     else if (r_cnt == CNT_W'(1))        w_state_nxt = FIXUP;
            FIXUP:   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_acc_hi  <= '0;
            r_acc_lo  <= '0;
            r_operand <= '0;
            r_is_div  <= 1'b0;
            r_neg_lo  <= 1'b0;
            r_neg_hi  <= 1'b0;
            r_div0    <= 1'b0;
            r_hi      <= '0;
            r_lo      <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_done  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (start && !flush) begin
                        if (op == MD_MTHI) begin
                            r_hi <= a;
                        end else if (op == MD_MTLO) begin
                            r_lo <= a;
                        end else if (w_arith_op) begin
                            r_is_div <= op[1];
                            r_neg_lo <= w_sa ^ w_sb;
                            r_neg_hi <= w_sa;
                            r_div0   <= (b == '0);
                            r_cnt    <= CNT_W'(WIDTH);
                            r_acc_hi <= '0;
                            // Multiply keeps the multiplier in acc_lo;
                            // divide keeps the dividend there.
                            r_acc_lo  <= op[1] ? w_abs_a : w_abs_b;
                            r_operand <= op[1] ? w_abs_b : w_abs_a;
                        end
                    end
                end
                CALC: begin
                    if (!flush) begin
                        r_acc_hi <= w_step_hi;
                        r_acc_lo <= w_step_lo;
                        r_cnt    <= r_cnt - 1'b1;
                    end
                end
                FIXUP: begin
                    if (!flush) begin
                        if (r_is_div) begin
                            r_hi <= w_rem_fix;
                            r_lo <= w_quot_fix;
                        end else begin
                            r_hi <= w_prod_fix[2*WIDTH-1:WIDTH];
                            r_lo <= w_prod_fix[WIDTH-1:0];
                        end
                        r_done <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign busy = (r_state != IDLE);
    assign done = r_done;
    assign hi   = r_hi;
    assign lo   = r_lo;

endmodule
`default_nettype wire

// File: tb/tb_mips_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : tb_mips_muldiv
// Purpose  : Directed self-checking bench for mips_muldiv (WIDTH=32).
//            Instance dut_s has signed support, dut_u has SIGNED_EN=0.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mips_muldiv;
    import mips_muldiv_pkg::*;

    localparam int W = 32;

    logic         clk = 1'b0;
    logic         reset;
    logic         start_s;
    logic         start_u;
    logic         flush;
    logic [2:0]   op;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy_s, done_s, busy_u, done_u;
    logic [W-1:0] hi_s, lo_s, hi_u, lo_u;

    int err_cnt = 0;
    int chk_cnt = 0;

    always #5 clk = ~clk;

    mips_muldiv #(.WIDTH(W), .SIGNED_EN(1'b1)) dut_s (
        .clk   (clk),
        .reset (reset),
        .start (start_s),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy_s),
        .done  (done_s),
        .hi    (hi_s),
        .lo    (lo_s)
    );

    mips_muldiv #(.WIDTH(W), .SIGNED_EN(1'b0)) dut_u (
        .clk   (clk),
        .reset (reset),
        .start (start_u),
        .op    (op),
        .a     (a),
        .b     (b),
        .flush (flush),
        .busy  (busy_u),
        .done  (done_u),
        .hi    (hi_u),
        .lo    (lo_u)
    );

    task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
        chk_cnt++;
        if (act !== exp) begin
            err_cnt++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // Issue one arithmetic op, wait for busy to fall (bounded), check the
    // latency, done pulse, results, and that done is a single cycle.
    task automatic run_op(input bit use_u, input logic [2:0] o,
                          input logic [W-1:0] x, input logic [W-1:0] y,
                          input logic [W-1:0] exp_hi, input logic [W-1:0] exp_lo,
                          input string tag);
        int n;
        n  = 0;
        op = o;
        a  = x;
        b  = y;
        if (use_u) start_u = 1'b1;
        else       start_s = 1'b1;
        tick();
        start_s = 1'b0;
        start_u = 1'b0;
        while ((use_u ? busy_u : busy_s) && n < 100) begin
            n++;
            tick();
        end
        check({tag, " busy cycles"}, 64'(n), 64'd33);
        check({tag, " done"}, 64'(use_u ? done_u : done_s), 64'd1);
        check({tag, " hi"}, 64'(use_u ? hi_u : hi_s), 64'(exp_hi));
        check({tag, " lo"}, 64'(use_u ? lo_u : lo_s), 64'(exp_lo));
        tick();
        check({tag, " done pulse"}, 64'(use_u ? done_u : done_s), 64'd0);
    endtask

    initial begin
        reset = 1'b1; start_s = 1'b0; start_u = 1'b0; flush = 1'b0;
        op = 3'd0; a = '0; b = '0;
        tick();
        tick();
        reset = 1'b0;
        check("reset hi",   64'(hi_s),   64'd0);
        check("reset lo",   64'(lo_s),   64'd0);
        check("reset busy", 64'(busy_s), 64'd0);
        check("reset done", 64'(done_s), 64'd0);

        // Multiply
        run_op(1'b0, MD_MULT,  32'hFFFF_FFFD, 32'd7,        32'hFFFF_FFFF, 32'hFFFF_FFEB, "mult -3x7");
        run_op(1'b0, MD_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, "multu max");
        run_op(1'b0, MD_MULT,  32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, "mult -1x-1");

        // Divide
        run_op(1'b0, MD_DIV,  32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFFF, 32'hFFFF_FFFD, "div -7/2");
        run_op(1'b0, MD_DIVU, 32'd7,         32'd0,         32'd7,         32'hFFFF_FFFF, "divu 7/0");
        run_op(1'b0, MD_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 32'd0,         32'h8000_0000, "div min/-1");
        run_op(1'b0, MD_DIV,  32'd100,       32'hFFFF_FFF9, 32'd2,         32'hFFFF_FFF2, "div 100/-7");
        run_op(1'b0, MD_DIV,  32'hFFFF_FFF9, 32'd0,         32'hFFFF_FFF9, 32'hFFFF_FFFF, "div -7/0");

        // MTHI / MTLO on consecutive cycles
        op = MD_MTHI; a = 32'h1234; start_s = 1'b1;
        tick();
        check("mthi hi", 64'(hi_s), 64'h1234);
        op = MD_MTLO; a = 32'h5678;
        tick();
        start_s = 1'b0;
        check("mtlo lo", 64'(lo_s), 64'h5678);
        check("mtlo busy", 64'(busy_s), 64'd0);

        // MULT aborted by flush in cycle 10; MTHI during busy ignored
        op = MD_MULT; a = 32'd3; b = 32'd5; start_s = 1'b1;
        tick();                       // cycle 1
        start_s = 1'b0;
        tick();                       // cycle 2
        op = MD_MTHI; a = 32'hDEAD; start_s = 1'b1;
        tick();                       // cycle 3
        start_s = 1'b0;
        for (int i = 0; i < 7; i++) tick();   // cycle 10
        check("flush pre busy", 64'(busy_s), 64'd1);
        flush = 1'b1;
        tick();                       // cycle 11
        flush = 1'b0;
        check("flush busy", 64'(busy_s), 64'd0);
        check("flush done", 64'(done_s), 64'd0);
        check("flush hi",   64'(hi_s),   64'h1234);
        check("flush lo",   64'(lo_s),   64'h5678);
        tick();
        check("flush done later", 64'(done_s), 64'd0);

        // flush in IDLE blocks a same-cycle start
        op = MD_MTHI; a = 32'hBEEF; start_s = 1'b1; flush = 1'b1;
        tick();
        start_s = 1'b0; flush = 1'b0;
        check("idle flush hi", 64'(hi_s), 64'h1234);

        // Reserved op code ignored
        op = 3'd6; a = 32'h1111; b = 32'h2222; start_s = 1'b1;
        tick();
        start_s = 1'b0;
        check("reserved busy", 64'(busy_s), 64'd0);
        tick();
        check("reserved done", 64'(done_s), 64'd0);
        check("reserved lo",   64'(lo_s),   64'h5678);

        // Reset during a DIVU, in its cycle 5
        op = MD_DIVU; a = 32'd100; b = 32'd3; start_s = 1'b1;
        tick();                       // cycle 1
        start_s = 1'b0;
        for (int i = 0; i < 4; i++) tick();   // cycle 5
        reset = 1'b1;
        tick();
        reset = 1'b0;
        check("midreset hi",   64'(hi_s),   64'd0);
        check("midreset lo",   64'(lo_s),   64'd0);
        check("midreset busy", 64'(busy_s), 64'd0);
        check("midreset done", 64'(done_s), 64'd0);

        // SIGNED_EN=0: MULT and DIV run unsigned
        run_op(1'b1, MD_MULT, 32'hFFFF_FFFF, 32'd2, 32'h0000_0001, 32'hFFFF_FFFE, "u mult -1x2");
        run_op(1'b1, MD_DIV,  32'hFFFF_FFF9, 32'd2, 32'h0000_0001, 32'h7FFF_FFFC, "u div");

        $display("Result: errors=%0d of %0d checks", err_cnt, chk_cnt);
        $finish;
    end

endmodule
`default_nettype wire
